data_break_arbiter: RTL
=======================

DATA_BREAK_ARBITER -- requirements
Module: data_break_arbiter

Interface
REQ-001 Parameter NREQ, default 4: number of data-break requesters, range 2..4.
REQ-002 Parameter ROTATE, default 0: 0 selects fixed priority (index 0 highest); 1 selects rotating priority.
REQ-003 clk  input  1  system clock.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 req  input  NREQ  per-device break request, level.
REQ-006 req_wr  input  NREQ  per-device direction: 1 = device writes memory; 0 = memory read to device.
REQ-007 req_addr  input  NREQ x 12  per-device word address, bit 0 MSB.
REQ-008 req_field  input  NREQ x 3  per-device extended memory field.
REQ-009 break_in_prog  input  1  high while the CPU sequencer occupies its break cycles (DB0/DB1).
REQ-010 data_break  output  1  break request to the CPU sequencer.
REQ-011 to_disk  output  1  direction of the granted break: 1 = memory read (data to device).
REQ-012 break_addr  output  12  latched address of the granted break.
REQ-013 break_field  output  3  latched field of the granted break.
REQ-014 grant  output  NREQ  one-hot winner, held from latch to ack.
REQ-015 ack  output  NREQ  one-clock completion pulse to the winner.
REQ-016 busy  output  1  high in every state except IDLE.

Function
REQ-017 The FSM SHALL have the states IDLE, PEND, XFER and DONE, with encodings in the shared package.
REQ-018 IDLE: when any req bit is high, the FSM SHALL select a winner, latch req_wr/addr/field into to_disk/break_addr/break_field, set grant, assert data_break, and go to PEND on the next edge.
REQ-019 The to_disk output SHALL equal the inverse of the winner's req_wr.
REQ-020 PEND: data_break SHALL stay high; when break_in_prog=1, the FSM SHALL clear data_break and go to XFER.
REQ-021 XFER: when break_in_prog=0, the FSM SHALL go to DONE.
REQ-022 DONE: the FSM SHALL pulse the winner's ack bit for exactly one clock, clear grant, and return to IDLE.
REQ-023 Minimum latency from req to data_break is 1 clock; minimum spacing between consecutive data_break assertions is 1 IDLE clock after DONE.
REQ-024 Fixed priority SHALL make the lowest-index active req win.
REQ-025 Rotating priority SHALL start the search at ptr, a 2-bit pointer with reset value 0; in DONE, ptr SHALL become (winner+1) mod NREQ.
REQ-026 Latched outputs SHALL stay stable from IDLE exit until DONE, regardless of req or req_addr changes.
REQ-027 If the winner drops req before ack, the arbiter SHALL still complete the cycle and pulse ack; requesters SHALL hold req until ack.
REQ-028 A requester SHALL drop req in the cycle after ack, or it requests again.
REQ-029 A new req arriving during PEND, XFER or DONE SHALL wait; it SHALL NOT pre-empt the cycle in progress.
REQ-030 break_in_prog=1 while in IDLE SHALL be ignored; no state change, no ack.
REQ-031 While the CPU is halted (no F3/D3/E3 reached), the FSM SHALL remain in PEND indefinitely, with no timeout.

Reset
REQ-032 Assertion of reset SHALL immediately force state=IDLE, data_break=0, to_disk=0, break_addr=0, break_field=0, grant=0, ack=0, ptr=0, busy=0.
REQ-033 A reset during PEND or XFER SHALL abandon the break without an ack; the requester SHALL re-request.
REQ-034 Deassertion SHALL take effect at the first clk edge following release.

Structure
REQ-035 FSM state encodings and the NREQ maximum SHALL be placed in the shared parameters.v include.
REQ-036 Winner selection SHALL be a sub-module db_priority: inputs req and ptr; output one-hot winner and 2-bit index; purely combinational.
REQ-037 Estimated size is 150-300 lines of RTL in total.

Verification
REQ-038 Test 1: req=0001, req_wr=1, addr=o1234, field=2; break_in_prog rises 3 clocks after data_break and is high for 2 clocks -> data_break high 1 clock after req; to_disk=0; break_addr=o1234; ack=0001 pulses once, 1 clock after break_in_prog falls.
REQ-039 Test 2: fixed priority, req=1010 together -> first grant=0010, second grant=1000, each with a single ack.
REQ-040 Test 3: ROTATE=1, req=1111 held with re-request after each ack -> grant order 0001, 0010, 0100, 1000, 0001.
REQ-041 Test 4: req_addr changes from o0100 to o0200 during PEND -> break_addr stays o0100 until DONE.
REQ-042 Test 5: reset asserted during XFER -> all outputs 0 asynchronously; no ack; after release, a held req restarts at PEND.
REQ-043 Test 6: winner drops req during PEND -> cycle completes; ack pulses; FSM returns to IDLE with busy=0.

Source files
------------

// File: rtl/data_break_arbiter_pkg.sv
// rtl/data_break_arbiter_pkg.sv - shared state encodings, widths and pointer helper for the data-break arbiter
package data_break_arbiter_pkg;

   localparam int DB_NREQ_MAX = 4;
   localparam int DB_ADDR_W   = 12;
   localparam int DB_FIELD_W  = 3;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_PEND = 2'b01,
      ST_XFER = 2'b10,
      ST_DONE = 2'b11
   } db_state_t;

   // Rotating pointer advance: one past the last winner, wrapping at nreq.
   function automatic logic [1:0] db_next_ptr(input logic [1:0] idx, input int nreq);
      logic [2:0] n;
      n = {1'b0, idx} + 3'd1;
      if (int'(n) >= nreq) begin
         n = 3'd0;
      end
      return n[1:0];
   endfunction

endpackage

// File: rtl/data_break_arbiter_db_priority.sv
// rtl/data_break_arbiter_db_priority.sv - combinational winner selection, fixed or rotating priority
module db_priority
   import data_break_arbiter_pkg::*;
#(
   parameter int NREQ   = 4,
   parameter int ROTATE = 0
) (
   input  logic [NREQ-1:0] req,
   input  logic [1:0]      ptr,
   output logic [NREQ-1:0] winner,
   output logic [1:0]      index
);

   logic [2*NREQ-1:0] w_req2;
   logic [NREQ-1:0]   w_rot;
   int                w_start;
   int                w_pos;
   logic              w_found;

   // Rotate the request vector so the search always begins at bit 0, then map back.
   always_comb begin
      winner  = '0;
      index   = 2'd0;
      w_found = 1'b0;
      w_pos   = 0;
      w_start = (ROTATE != 0) ? int'(ptr) : 0;
      if (w_start >= NREQ) begin
         w_start = 0;
      end
      w_req2 = {req, req};
      w_rot  = w_req2[w_start +: NREQ];
      for (int j = 0; j < NREQ; j++) begin
         if (!w_found && w_rot[j]) begin
            w_found = 1'b1;
            w_pos   = w_start + j;
            if (w_pos >= NREQ) begin
               w_pos = w_pos - NREQ;
            end
         end
      end
      if (w_found) begin
         winner[w_pos] = 1'b1;
         index         = w_pos[1:0];
      end
   end

endmodule

// File: rtl/data_break_arbiter.sv
// rtl/data_break_arbiter.sv - arbitrates device data-break requests into single CPU break cycles
module data_break_arbiter
   import data_break_arbiter_pkg::*;
#(
   parameter int NREQ   = 4,
   parameter int ROTATE = 0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NREQ-1:0]        req,
   input  logic [NREQ-1:0]        req_wr,
   input  logic [NREQ*12-1:0]     req_addr,
   input  logic [NREQ*3-1:0]      req_field,
   input  logic                   break_in_prog,
   output logic                   data_break,
   output logic                   to_disk,
   output logic [11:0]            break_addr,
   output logic [2:0]             break_field,
   output logic [NREQ-1:0]        grant,
   output logic [NREQ-1:0]        ack,
   output logic                   busy
);

   db_state_t        r_state;
   db_state_t        w_next_state;
   logic             r_data_break;
   logic             r_to_disk;
   logic [11:0]      r_break_addr;
   logic [2:0]       r_break_field;
   logic [NREQ-1:0]  r_grant;
   logic [NREQ-1:0]  r_ack;
   logic [1:0]       r_ptr;
   logic [1:0]       r_win_idx;

   logic [NREQ-1:0]  w_winner;
   logic [1:0]       w_win_idx;
   logic [11:0]      w_sel_addr;
   logic [2:0]       w_sel_field;
   logic             w_sel_wr;
   logic             w_any_req;

   db_priority #(
      .NREQ   (NREQ),
      .ROTATE (ROTATE)
   ) u_prio (
      .req    (req),
      .ptr    (r_ptr),
      .winner (w_winner),
      .index  (w_win_idx)
   );

   assign w_any_req = |req;

   // Route the winning device's direction, address and field toward the latches.
   always_comb begin
      w_sel_addr  = 12'd0;
      w_sel_field = 3'd0;
      w_sel_wr    = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_winner[i]) begin
            w_sel_addr  = req_addr[i*12 +: 12];
            w_sel_field = req_field[i*3 +: 3];
            w_sel_wr    = req_wr[i];
         end
      end
   end

   // State register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic; the CPU handshake alone moves PEND and XFER, with no timeout.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE: if (w_any_req)      w_next_state = ST_PEND;
         ST_PEND: if (break_in_prog)  w_next_state = ST_XFER;
         ST_XFER: if (!break_in_prog) w_next_state = ST_DONE;
         ST_DONE:                     w_next_state = ST_IDLE;
         default:                     w_next_state = ST_IDLE;
      endcase
   end

   // Latch the winner on IDLE exit and hold it untouched until the DONE ack.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_data_break  <= 1'b0;
         r_to_disk     <= 1'b0;
         r_break_addr  <= 12'd0;
         r_break_field <= 3'd0;
         r_grant       <= '0;
         r_ack         <= '0;
         r_ptr         <= 2'd0;
         r_win_idx     <= 2'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_ack <= '0;
               if (w_any_req) begin
                  r_data_break  <= 1'b1;
                  r_to_disk     <= ~w_sel_wr;
                  r_break_addr  <= w_sel_addr;
                  r_break_field <= w_sel_field;
                  r_grant       <= w_winner;
                  r_win_idx     <= w_win_idx;
               end
            end
            ST_PEND: begin
               if (break_in_prog) begin
                  r_data_break <= 1'b0;
               end
            end
            ST_XFER: begin
               if (!break_in_prog) begin
                  r_ack <= r_grant;
               end
            end
            ST_DONE: begin
               r_ack   <= '0;
               r_grant <= '0;
               r_ptr   <= db_next_ptr(r_win_idx, NREQ);
            end
            default: begin
               r_ack <= '0;
            end
         endcase
      end
   end

   assign data_break  = r_data_break;
   assign to_disk     = r_to_disk;
   assign break_addr  = r_break_addr;
   assign break_field = r_break_field;
   assign grant       = r_grant;
   assign ack         = r_ack;
   assign busy        = (r_state != ST_IDLE);

endmodule
